// File: rtl/gpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// gpu_mem_pkg
// Shared types and default widths for the data-memory controller slice.
//   ctrl_state_t : controller sequencer states
//   mem_op_t     : operation latched for the granted channel
// -----------------------------------------------------------------------------
package gpu_mem_pkg;

  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_RELEASE,
    RESPOND
  } ctrl_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

endpackage

// File: rtl/data_mem_controller_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches req upward from ptr with wrap and
// returns the first requester. The pointer register lives in the caller.
//   req       : request vector, one bit per channel
//   ptr       : channel index the search starts from
//   en        : arbitration enable; all outputs are 0 when low
//   grant     : one-hot grant
//   grant_idx : binary index of the granted channel
//   found     : at least one request was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_CHANNELS = 4,
  localparam int IDX_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [IDX_BITS-1:0]     ptr,
  input  logic                    en,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [IDX_BITS-1:0]     grant_idx,
  output logic                    found
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value held and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        idx = (int'(ptr) + k) % NUM_CHANNELS;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IDX_BITS'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// -----------------------------------------------------------------------------
// data_mem_controller
// Shares one data memory between NUM_CHANNELS load/store requesters. Requests
// are serialised round-robin; both the memory side and the channel side use a
// four-phase valid/ready return-to-zero handshake.
//   clk, reset        : clock, synchronous active-high reset
//   ch_read_*         : per-channel read request/address, ready/data back
//   ch_write_*        : per-channel write request/address/data, ready back
//   mem_read_*        : memory read port (valid/addr out, ready/data in)
//   mem_write_*       : memory write port (valid/addr/data out, ready in)
//   busy              : sequencer is not idle
//   grant_id          : channel being served, 0 when idle
// -----------------------------------------------------------------------------
module data_mem_controller
  import gpu_mem_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int ADDR_BITS    = DEF_ADDR_BITS,
  parameter  int DATA_BITS    = DEF_DATA_BITS,
  localparam int IDX_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CHANNELS-1:0]        ch_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_addr,
  output logic [NUM_CHANNELS-1:0]        ch_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data,
  input  logic [NUM_CHANNELS-1:0]        ch_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_addr,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data,
  output logic [NUM_CHANNELS-1:0]        ch_write_ready,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_addr,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           mem_write_valid,
  output logic [ADDR_BITS-1:0]           mem_write_addr,
  output logic [DATA_BITS-1:0]           mem_write_data,
  input  logic                           mem_write_ready,
  output logic                           busy,
  output logic [IDX_BITS-1:0]            grant_id
);

  ctrl_state_t               state_q, state_d;
  logic [IDX_BITS-1:0]       ptr_q, grant_q;
  mem_op_t                   op_q;
  logic [ADDR_BITS-1:0]      addr_q;
  logic [DATA_BITS-1:0]      wdata_q, rdata_q;

  logic [NUM_CHANNELS-1:0]   req, arb_grant;
  logic [IDX_BITS-1:0]       arb_idx;
  logic                      arb_found, arb_is_read, accept;
  logic                      mem_ready, ch_valid;

  // A channel asserting both valids is arbitrated as a read; its write stays
  // pending and wins a later grant of its own.
  assign req         = ch_read_valid | ch_write_valid;
  assign arb_is_read = |(arb_grant & ch_read_valid);
  assign accept      = (state_q == IDLE) && arb_found;

  rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .en        (state_q == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .found     (arb_found)
  );

  assign mem_ready = (op_q == OP_READ) ? mem_read_ready : mem_write_ready;
  assign ch_valid  = (op_q == OP_READ) ? ch_read_valid[grant_q] : ch_write_valid[grant_q];

  // Control state: reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge value of its sources regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= arb_idx;
        op_q    <= arb_is_read ? OP_READ : OP_WRITE;
        ptr_q   <= (arb_idx == IDX_BITS'(NUM_CHANNELS - 1)) ? '0 : arb_idx + IDX_BITS'(1);
      end
    end
  end

  // Datapath: address/data latches and the captured read data.
  // NOTE: these carry no reset; they are only observed through outputs that
  // are gated by the (reset) state, so a stale value never escapes.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= arb_is_read ? ch_read_addr[arb_idx*ADDR_BITS +: ADDR_BITS]
                             : ch_write_addr[arb_idx*ADDR_BITS +: ADDR_BITS];
      wdata_q <= ch_write_data[arb_idx*DATA_BITS +: DATA_BITS];
    end
    if (state_q == MEM_REQ && op_q == OP_READ && mem_read_ready) begin
      rdata_q <= mem_read_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (arb_found) state_d = MEM_REQ;
      MEM_REQ:     if (mem_ready) state_d = MEM_RELEASE;
      MEM_RELEASE: if (!mem_ready) state_d = RESPOND;
      RESPOND:     if (!ch_valid) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Outputs, decoded from the registered state so reset clears them at once.
  always_comb begin
    mem_read_valid  = 1'b0;
    mem_read_addr   = '0;
    mem_write_valid = 1'b0;
    mem_write_addr  = '0;
    mem_write_data  = '0;
    ch_read_ready   = '0;
    ch_write_ready  = '0;
    ch_read_data    = '0;

    if (state_q == MEM_REQ || state_q == MEM_RELEASE) begin
      if (op_q == OP_READ) begin
        mem_read_addr  = addr_q;
      end else begin
        mem_write_addr = addr_q;
        mem_write_data = wdata_q;
      end
    end

    if (state_q == MEM_REQ) begin
      if (op_q == OP_READ) mem_read_valid  = 1'b1;
      else                 mem_write_valid = 1'b1;
    end

    if (state_q == RESPOND) begin
      if (op_q == OP_READ) begin
        ch_read_ready[grant_q]                    = 1'b1;
        ch_read_data[grant_q*DATA_BITS +: DATA_BITS] = rdata_q;
      end else begin
        ch_write_ready[grant_q] = 1'b1;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = busy ? grant_q : '0;

endmodule

// File: tb/tb_data_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_data_mem_controller
// Directed bench for data_mem_controller with four channels. A behavioural
// memory answers with combinational ready (optionally stretched one cycle).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_mem_controller;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    ch_read_valid, ch_read_ready, ch_write_valid, ch_write_ready;
  logic [N*AW-1:0] ch_read_addr, ch_write_addr;
  logic [N*DW-1:0] ch_read_data, ch_write_data;
  logic            mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [AW-1:0]   mem_read_addr, mem_write_addr;
  logic [DW-1:0]   mem_read_data, mem_write_data;
  logic            busy;
  logic [1:0]      grant_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_controller #(.NUM_CHANNELS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ch_read_valid   (ch_read_valid),
    .ch_read_addr    (ch_read_addr),
    .ch_read_ready   (ch_read_ready),
    .ch_read_data    (ch_read_data),
    .ch_write_valid  (ch_write_valid),
    .ch_write_addr   (ch_write_addr),
    .ch_write_data   (ch_write_data),
    .ch_write_ready  (ch_write_ready),
    .mem_read_valid  (mem_read_valid),
    .mem_read_addr   (mem_read_addr),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .mem_write_valid (mem_write_valid),
    .mem_write_addr  (mem_write_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_ready (mem_write_ready),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  // Behavioural data memory. With stretch set, ready stays high one cycle
  // after valid falls so the release phase has to wait.
  logic [DW-1:0] mem [256];
  logic          stretch, rd_hold_q, wr_hold_q;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always_comb begin
    mem_read_ready  = mem_read_valid | rd_hold_q;
    mem_write_ready = mem_write_valid | wr_hold_q;
    mem_read_data   = mem_read_valid ? mem[mem_read_addr] : '0;
  end

  always @(posedge clk) begin
    rd_hold_q <= stretch & mem_read_valid;
    wr_hold_q <= stretch & mem_write_valid;
    if (mem_write_valid) mem[mem_write_addr] <= mem_write_data;
    if (pre_we)          mem[pre_addr]       <= pre_data;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    tick();
    pre_we = 1'b0;
  endtask

  // Wait (bounded) for any read or write ready.
  task automatic wait_any(input bit is_write, input string tag);
    int n;
    n = 0;
    while (!(is_write ? |ch_write_ready : |ch_read_ready) && n < 30) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 30) else begin
      failures++;
      $error("FAIL %s_timeout: observed=%0d cycles expected=<30", tag, n);
    end
  endtask

  // Expect the next read completion to go to channel ch with data exp,
  // then finish the handshake.
  task automatic read_expect(input int ch, input logic [7:0] exp, input string tag);
    wait_any(1'b0, tag);
    check({tag, "_rready"}, 32'(ch_read_ready), 32'(1) << ch);
    check({tag, "_grant"},  32'(grant_id),      32'(ch));
    check({tag, "_rdata"},  ch_read_data,       32'(exp) << (ch * 8));
    ch_read_valid[ch] = 1'b0;
    tick();
    check({tag, "_rdrop"},  {ch_read_ready, ch_read_data[27:0]}, 32'h0);
  endtask

  task automatic do_read(input int ch, input logic [7:0] addr, input logic [7:0] exp,
                         input string tag);
    ch_read_addr[ch*8 +: 8] = addr;
    ch_read_valid[ch]       = 1'b1;
    read_expect(ch, exp, tag);
  endtask

  task automatic do_write(input int ch, input logic [7:0] addr, input logic [7:0] data,
                          input string tag);
    ch_write_addr[ch*8 +: 8] = addr;
    ch_write_data[ch*8 +: 8] = data;
    ch_write_valid[ch]       = 1'b1;
    wait_any(1'b1, tag);
    check({tag, "_wready"}, 32'(ch_write_ready), 32'(1) << ch);
    check({tag, "_grant"},  32'(grant_id),       32'(ch));
    check({tag, "_mem"},    32'(mem[addr]),      32'(data));
    ch_write_valid[ch] = 1'b0;
    tick();
    check({tag, "_wdrop"},  {27'h0, ch_write_ready, busy}, 32'h0);
  endtask

  initial begin
    reset          = 1'b1;
    stretch        = 1'b0;
    pre_we         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;
    ch_read_valid  = '0;
    ch_write_valid = '0;
    ch_read_addr   = '0;
    ch_write_addr  = '0;
    ch_write_data  = '0;
    @(negedge clk);
    tick();

    // Reset state.
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_grant",  32'(grant_id), 32'h0);
    check("rst_mem",    {30'h0, mem_read_valid, mem_write_valid}, 32'h0);
    check("rst_ready",  {24'h0, ch_read_ready, ch_write_ready}, 32'h0);
    reset = 1'b0;

    // Single read with cycle-by-cycle timing.
    preload(8'h10, 8'hA5);
    ch_read_addr[15:8] = 8'h10;
    ch_read_valid[1]   = 1'b1;
    tick();
    check("t1_mreq_valid", 32'(mem_read_valid), 32'h1);
    check("t1_mreq_addr",  32'(mem_read_addr),  32'h10);
    check("t1_busy_grant", {30'h0, busy, grant_id[0]} | 32'(grant_id) << 4, 32'h13);
    tick();
    check("t1_rel_valid",  32'(mem_read_valid), 32'h0);
    check("t1_rel_addr",   32'(mem_read_addr),  32'h10);
    check("t1_rel_ready",  32'(ch_read_ready),  32'h0);
    tick();
    check("t1_resp_ready", 32'(ch_read_ready),  32'h2);
    check("t1_resp_data",  ch_read_data,        32'h0000A500);
    ch_read_valid[1] = 1'b0;
    tick();
    check("t1_done_ready", 32'(ch_read_ready),  32'h0);
    check("t1_done_data",  ch_read_data,        32'h0);
    check("t1_done_busy",  32'(busy),           32'h0);
    check("t1_done_grant", 32'(grant_id),       32'h0);

    // Write then read back through another channel.
    do_write(0, 8'h80, 8'h3C, "t2_wr");
    do_read(2, 8'h80, 8'h3C, "t2_rd");

    // Contention: pointer back to 0, all four channels read together.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) preload(8'(8'h20 + i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) ch_read_addr[i*8 +: 8] = 8'(8'h20 + i);
    ch_read_valid = 4'b1111;
    read_expect(0, 8'h11, "t3_a0");
    read_expect(1, 8'h22, "t3_a1");
    read_expect(2, 8'h33, "t3_a2");
    read_expect(3, 8'h44, "t3_a3");
    ch_read_valid = 4'b1111;
    read_expect(0, 8'h11, "t3_b0");
    read_expect(1, 8'h22, "t3_b1");
    read_expect(2, 8'h33, "t3_b2");
    read_expect(3, 8'h44, "t3_b3");
    ch_read_valid = 4'b1001;
    read_expect(0, 8'h11, "t3_c0");
    read_expect(3, 8'h44, "t3_c3");

    // Same channel read and write: old value first, then the write.
    preload(8'h05, 8'h5A);
    ch_read_addr[23:16]  = 8'h05;
    ch_write_addr[23:16] = 8'h05;
    ch_write_data[23:16] = 8'h77;
    ch_read_valid[2]     = 1'b1;
    ch_write_valid[2]    = 1'b1;
    read_expect(2, 8'h5A, "t4_rd_old");
    wait_any(1'b1, "t4_wr");
    check("t4_wr_ready", 32'(ch_write_ready), 32'h4);
    check("t4_wr_grant", 32'(grant_id),       32'h2);
    check("t4_wr_mem",   32'(mem[8'h05]),     32'h77);
    ch_write_valid[2] = 1'b0;
    tick();
    check("t4_wr_drop",  32'(ch_write_ready), 32'h0);
    do_read(1, 8'h05, 8'h77, "t4_rd_new");

    // Reset while the memory request is outstanding.
    ch_read_addr[7:0] = 8'h10;
    ch_read_valid[0]  = 1'b1;
    tick();
    check("t5_mreq",  32'(mem_read_valid), 32'h1);
    reset = 1'b1;
    tick();
    check("t5_abort", {27'h0, mem_read_valid, mem_write_valid, busy, grant_id}, 32'h0);
    check("t5_ready", {24'h0, ch_read_ready, ch_write_ready}, 32'h0);
    reset = 1'b0;
    read_expect(0, 8'hA5, "t5_after");

    // Requester withdraws during the release phase.
    ch_read_addr[15:8] = 8'h21;
    ch_read_valid[1]   = 1'b1;
    tick();
    tick();
    check("t6_release", {30'h0, busy, mem_read_valid}, 32'h2);
    ch_read_valid[1] = 1'b0;
    tick();
    check("t6_ready_hi", 32'(ch_read_ready), 32'h2);
    check("t6_data",     ch_read_data,       32'h00002200);
    tick();
    check("t6_ready_lo", {27'h0, ch_read_ready, busy}, 32'h0);
    do_read(3, 8'h23, 8'h44, "t6_next");

    // Memory holds ready one extra cycle: release must wait for it.
    stretch = 1'b1;
    ch_read_addr[7:0] = 8'h22;
    ch_read_valid[0]  = 1'b1;
    tick();
    tick();
    tick();
    check("t7_wait", {27'h0, ch_read_ready, busy}, 32'h1);
    tick();
    check("t7_ready", 32'(ch_read_ready), 32'h1);
    check("t7_data",  ch_read_data,       32'h00000033);
    ch_read_valid[0] = 1'b0;
    tick();
    stretch = 1'b0;
    tick();

    // Address range extremes.
    do_write(3, 8'hFF, 8'hC3, "t8_wr_ff");
    do_read(2, 8'hFF, 8'hC3, "t8_rd_ff");
    do_write(1, 8'h00, 8'h96, "t8_wr_00");
    do_read(0, 8'h00, 8'h96, "t8_rd_00");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
